// File: rtl/peak_to_dds_cfg_if.sv
// Handshake bundle for peak_to_dds_cfg.
//   s_axis_*        : peak result stream into the block (bin index + amplitude)
//   m_axis_config_* : DDS phase-increment config stream out of the block
// Modports:
//   master : the environment side (drives peaks, consumes config words)
//   slave  : the peak_to_dds_cfg side
interface peak_to_dds_cfg_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int AMP_WIDTH  = 25
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [ADDR_WIDTH-1:0] s_axis_taddr;
    logic [AMP_WIDTH-1:0]  s_axis_tamp;

    logic                  m_axis_config_tvalid;
    logic                  m_axis_config_tready;
    logic [31:0]           m_axis_config_tdata;

    modport master (
        output s_axis_tvalid, s_axis_taddr, s_axis_tamp,
        input  s_axis_tready,
        input  m_axis_config_tvalid, m_axis_config_tdata,
        output m_axis_config_tready
    );

    modport slave (
        input  s_axis_tvalid, s_axis_taddr, s_axis_tamp,
        output s_axis_tready,
        output m_axis_config_tvalid, m_axis_config_tdata,
        input  m_axis_config_tready
    );
endinterface

// File: rtl/peak_to_dds_cfg.sv
// peak_to_dds_cfg
// Converts a spectral peak (FFT bin index + root-sum-square amplitude) into a
// DDS phase-increment config word and a 16-bit amplitude word. Both products
// (bin * PINC_PER_BIN and amp * amp_gain) are formed by one shared-schedule
// sequential shift-add multiplier, one bit per cycle.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous reset, active low
//   bus            : peak_to_dds_cfg_if.slave (s_axis peak in, m_axis_config out)
//   amp_gain       : calibration gain, captured when a peak is accepted
//   amp_word       : DDS amplitude word, held between updates
//   amp_word_valid : one-cycle pulse when amp_word updates
//   busy           : high whenever the FSM is not in IDLE
//
// Build option:
//   PEAK_AVG_EN : when defined, amplitudes are averaged over 2^AVG_LOG2 accepted
//                 frames and only the last frame of each group produces output.
//
// state | meaning
// IDLE  | ready for a peak result
// MUL   | shift-add iterations for pinc and amplitude products
// SAT   | wrap pinc, scale and saturate amplitude, register outputs
// OUT   | hold config word until the DDS takes it
module peak_to_dds_cfg #(
    parameter int          ADDR_WIDTH   = 16,
    parameter int          AMP_WIDTH    = 25,
    parameter int          PHASE_WIDTH  = 28,
    parameter logic [31:0] PINC_PER_BIN = 32'd4096,
    parameter int          AMP_SHIFT    = 15,
    parameter int          AVG_LOG2     = 2
) (
    input  logic             clk,
    input  logic             rst,
    peak_to_dds_cfg_if.slave bus,
    input  logic [15:0]      amp_gain,
    output logic [15:0]      amp_word,
    output logic             amp_word_valid,
    output logic             busy
);
    localparam int LOOP  = (ADDR_WIDTH > 16) ? ADDR_WIDTH : 16;
    localparam int CNT_W = $clog2(LOOP);
    localparam int AP_W  = AMP_WIDTH + 16;
    localparam int AS_W  = AP_W - AMP_SHIFT;
    localparam logic [ADDR_WIDTH-1:0] HALF_BIN  = ADDR_WIDTH'(1) << (ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(LOOP - 1);

    typedef enum logic [1:0] {IDLE, MUL, SAT, OUT} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       iter;
    // pinc only needs to be correct modulo 2^PHASE_WIDTH, so its multiplier
    // datapath is kept at PHASE_WIDTH bits and wraps naturally.
    logic [PHASE_WIDTH-1:0] pinc_mcand;
    logic [PHASE_WIDTH-1:0] pinc_acc;
    logic [LOOP-1:0]        pinc_mplier;
    logic [AP_W-1:0]        amp_mcand;
    logic [AP_W-1:0]        amp_acc;
    logic [LOOP-1:0]        amp_mplier;

    logic                   s_tready_q;
    logic                   m_tvalid_q;
    logic [31:0]            m_tdata_q;

    logic                   accept;
    logic [ADDR_WIDTH-1:0]  bin_fold;
    logic [AMP_WIDTH-1:0]   amp_in;
    logic [AS_W-1:0]        amp_shr;
    logic [15:0]            amp_sat;
    logic                   amp_lsb_unused;
    logic                   skip_out;

    assign accept   = bus.s_axis_tvalid && s_tready_q;

    // Bins above N/2 are the negative-frequency mirror: use N - bin.
    assign bin_fold = (bus.s_axis_taddr > HALF_BIN) ? (ADDR_WIDTH'(0) - bus.s_axis_taddr)
                                                    : bus.s_axis_taddr;

    assign amp_shr        = amp_acc[AP_W-1:AMP_SHIFT];
    assign amp_lsb_unused = ^amp_acc[AMP_SHIFT-1:0];
    assign amp_sat        = (|amp_shr[AS_W-1:16]) ? 16'hFFFF : amp_shr[15:0];

`ifdef PEAK_AVG_EN
    localparam int SUM_W = AMP_WIDTH + AVG_LOG2;
    logic [SUM_W-1:0]    amp_sum;
    logic [SUM_W-1:0]    amp_sum_next;
    logic [AVG_LOG2-1:0] frame_cnt;
    logic                skip_q;
    logic                sum_lsb_unused;

    assign amp_sum_next   = amp_sum + SUM_W'(bus.s_axis_tamp);
    assign amp_in         = amp_sum_next[SUM_W-1:AVG_LOG2];
    assign sum_lsb_unused = ^amp_sum_next[AVG_LOG2-1:0];
    assign skip_out       = skip_q;
`else
    assign amp_in   = bus.s_axis_tamp;
    assign skip_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            iter           <= '0;
            pinc_mcand     <= '0;
            pinc_mplier    <= '0;
            pinc_acc       <= '0;
            amp_mcand      <= '0;
            amp_mplier     <= '0;
            amp_acc        <= '0;
            s_tready_q     <= 1'b0;
            m_tvalid_q     <= 1'b0;
            m_tdata_q      <= '0;
            amp_word       <= '0;
            amp_word_valid <= 1'b0;
`ifdef PEAK_AVG_EN
            amp_sum        <= '0;
            frame_cnt      <= '0;
            skip_q         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    s_tready_q <= 1'b1;
                    if (accept) begin
                        s_tready_q  <= 1'b0;
                        iter        <= '0;
                        pinc_mcand  <= PINC_PER_BIN[PHASE_WIDTH-1:0];
                        pinc_mplier <= LOOP'(bin_fold);
                        pinc_acc    <= '0;
                        amp_mcand   <= AP_W'(amp_in);
                        amp_mplier  <= LOOP'(amp_gain);
                        amp_acc     <= '0;
                        state       <= MUL;
`ifdef PEAK_AVG_EN
                        // Non-final frames only accumulate; they pass through
                        // SAT for one cycle with output suppressed.
                        frame_cnt <= frame_cnt + 1'b1;
                        if (&frame_cnt) begin
                            amp_sum <= '0;
                        end else begin
                            amp_sum <= amp_sum_next;
                            skip_q  <= 1'b1;
                            state   <= SAT;
                        end
`endif
                    end
                end

                MUL: begin
                    if (pinc_mplier[0]) pinc_acc <= pinc_acc + pinc_mcand;
                    if (amp_mplier[0])  amp_acc  <= amp_acc + amp_mcand;
                    pinc_mcand  <= pinc_mcand << 1;
                    pinc_mplier <= pinc_mplier >> 1;
                    amp_mcand   <= amp_mcand << 1;
                    amp_mplier  <= amp_mplier >> 1;
                    iter        <= iter + 1'b1;
                    if (iter == LAST_ITER) state <= SAT;
                end

                SAT: begin
                    if (skip_out) begin
`ifdef PEAK_AVG_EN
                        skip_q     <= 1'b0;
`endif
                        s_tready_q <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        m_tdata_q      <= 32'(pinc_acc);
                        m_tvalid_q     <= 1'b1;
                        amp_word       <= amp_sat;
                        amp_word_valid <= 1'b1;
                        state          <= OUT;
                    end
                end

                OUT: begin
                    amp_word_valid <= 1'b0;
                    // Ready goes high on the handshake edge so a new peak can
                    // be accepted on the very next edge.
                    if (bus.m_axis_config_tready) begin
                        m_tvalid_q <= 1'b0;
                        s_tready_q <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_axis_tready        = s_tready_q;
    assign bus.m_axis_config_tvalid = m_tvalid_q;
    assign bus.m_axis_config_tdata  = m_tdata_q;
    assign busy                     = (state != IDLE);
endmodule

// File: tb/tb_peak_to_dds_cfg.sv
// Self-checking bench for peak_to_dds_cfg: directed scenarios plus randomized
// frames compared against an arithmetic reference model.
module tb_peak_to_dds_cfg;
    localparam int          ADDR_WIDTH   = 16;
    localparam int          AMP_WIDTH    = 25;
    localparam int          PHASE_WIDTH  = 28;
    localparam longint      N_BINS       = 64'd1 << ADDR_WIDTH;
    localparam longint      PINC         = 4096;
    localparam int          AMP_SHIFT    = 15;
    localparam int          LATENCY      = 17;

    logic        clk;
    logic        rst;
    logic [15:0] amp_gain;
    logic [15:0] amp_word;
    logic        amp_word_valid;
    logic        busy;

    int vectors;
    int miscompares;

`ifdef PEAK_AVG_EN
    longint unsigned avg_sum;
    int              avg_cnt;
`endif

    peak_to_dds_cfg_if #(.ADDR_WIDTH(ADDR_WIDTH), .AMP_WIDTH(AMP_WIDTH)) bus ();

    peak_to_dds_cfg dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .amp_gain       (amp_gain),
        .amp_word       (amp_word),
        .amp_word_valid (amp_word_valid),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit, want completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: fold, multiply, wrap; scale and saturate.
    function automatic logic [31:0] model_tdata(input longint unsigned bin);
        longint unsigned b;
        b = (bin > N_BINS / 2) ? N_BINS - bin : bin;
        return 32'((b * PINC) % (64'd1 << PHASE_WIDTH));
    endfunction

    function automatic logic [15:0] model_amp(input longint unsigned amp, input longint unsigned gain);
        longint unsigned a;
        a = (amp * gain) >> AMP_SHIFT;
        return (a > 65535) ? 16'hFFFF : 16'(a);
    endfunction

    task automatic wait_out(input logic [31:0] exp_tdata, input logic [15:0] exp_amp, input string name);
        int n;
        n = 0;
        while (bus.m_axis_config_tvalid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != LATENCY) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, n, LATENCY);
        end
        vectors++;
        if (bus.m_axis_config_tdata !== exp_tdata) begin
            miscompares++;
            $display("FAIL %s tdata: got %h, want %h", name, bus.m_axis_config_tdata, exp_tdata);
        end
        vectors++;
        if (amp_word !== exp_amp) begin
            miscompares++;
            $display("FAIL %s amp_word: got %h, want %h", name, amp_word, exp_amp);
        end
        vectors++;
        if (amp_word_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s amp_word_valid: got %b, want 1", name, amp_word_valid);
        end
        if (bus.m_axis_config_tready === 1'b1) begin
            @(negedge clk);
            vectors++;
            if (bus.m_axis_config_tvalid !== 1'b0 || amp_word_valid !== 1'b0 ||
                bus.s_axis_tready !== 1'b1 || busy !== 1'b0 || amp_word !== exp_amp) begin
                miscompares++;
                $display("FAIL %s post: got tvalid=%b awv=%b s_tready=%b busy=%b amp=%h, want 0 0 1 0 %h",
                         name, bus.m_axis_config_tvalid, amp_word_valid, bus.s_axis_tready, busy,
                         amp_word, exp_amp);
            end
        end
    endtask

    task automatic do_frame(input logic [15:0] bin, input logic [24:0] amp, input logic [15:0] gain,
                            input bit exp_out, input logic [31:0] exp_tdata, input logic [15:0] exp_amp,
                            input string name);
        int to;
        to = 0;
        while (bus.s_axis_tready !== 1'b1 && to < 50) begin
            @(negedge clk);
            to++;
        end
        vectors++;
        if (to >= 50) begin
            miscompares++;
            $display("FAIL %s s_tready: got %b, want 1", name, bus.s_axis_tready);
            return;
        end
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_taddr  = bin;
        bus.s_axis_tamp   = amp;
        amp_gain          = gain;
        @(posedge clk);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_taddr  = 16'($urandom);
        bus.s_axis_tamp   = 25'($urandom);
        amp_gain          = 16'($urandom);
        vectors++;
        if (bus.s_axis_tready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept: got s_tready=%b busy=%b, want 0 1", name, bus.s_axis_tready, busy);
        end
        if (!exp_out) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || bus.s_axis_tready !== 1'b1 ||
                bus.m_axis_config_tvalid !== 1'b0 || amp_word_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s skip: got busy=%b s_tready=%b tvalid=%b awv=%b, want 0 1 0 0",
                         name, busy, bus.s_axis_tready, bus.m_axis_config_tvalid, amp_word_valid);
            end
            return;
        end
        wait_out(exp_tdata, exp_amp, name);
    endtask

    task automatic test_reset();
        rst               = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.s_axis_tready !== 1'b0 || bus.m_axis_config_tvalid !== 1'b0 ||
            bus.m_axis_config_tdata !== 32'h0 || amp_word !== 16'h0 || amp_word_valid !== 1'b0 ||
            busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got rdy=%b tv=%b td=%h aw=%h awv=%b busy=%b, want all 0",
                     bus.s_axis_tready, bus.m_axis_config_tvalid, bus.m_axis_config_tdata,
                     amp_word, amp_word_valid, busy);
        end
        bus.s_axis_tvalid = 1'b0;
        rst               = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.s_axis_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release s_tready: got %b, want 1", bus.s_axis_tready);
        end
        vectors++;
        if (bus.m_axis_config_tvalid !== 1'b0 || bus.m_axis_config_tdata !== 32'h0 ||
            amp_word !== 16'h0 || amp_word_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release outputs: got tv=%b td=%h aw=%h awv=%b busy=%b, want all 0",
                     bus.m_axis_config_tvalid, bus.m_axis_config_tdata, amp_word, amp_word_valid, busy);
        end
    endtask

    task automatic test_basic();
        do_frame(16'd10, 25'd1000, 16'h8000, 1'b1, 32'h0000A000, 16'd1000, "basic");
    endtask

    task automatic test_fold();
        do_frame(16'd65535, 25'd1000, 16'h8000, 1'b1, 32'h00001000, 16'd1000, "fold_65535");
        do_frame(16'd0,     25'd1000, 16'h8000, 1'b1, 32'h00000000, 16'd1000, "fold_0");
        do_frame(16'd32768, 25'd1000, 16'h8000, 1'b1, 32'h08000000, 16'd1000, "fold_half");
        do_frame(16'd32769, 25'd1000, 16'h8000, 1'b1, 32'h07FFF000, 16'd1000, "fold_half_plus1");
    endtask

    task automatic test_saturation();
        do_frame(16'd7, 25'h1FFFFFF, 16'hFFFF, 1'b1, 32'h00007000, 16'hFFFF, "sat_max");
        do_frame(16'd9, 25'd65535,   16'h8000, 1'b1, 32'h00009000, 16'hFFFF, "sat_edge_in");
        do_frame(16'd9, 25'd65536,   16'h8000, 1'b1, 32'h00009000, 16'hFFFF, "sat_edge_over");
        do_frame(16'd9, 25'd40000,   16'h4000, 1'b1, 32'h00009000, 16'd20000, "sat_none");
    endtask

    task automatic test_backpressure();
        bus.m_axis_config_tready = 1'b0;
        do_frame(16'd300, 25'd2000, 16'h8000, 1'b1, 32'h0012C000, 16'd2000, "bp_first");
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_taddr  = 16'd20;
        bus.s_axis_tamp   = 25'd500;
        amp_gain          = 16'h8000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.m_axis_config_tvalid !== 1'b1 || bus.m_axis_config_tdata !== 32'h0012C000 ||
                bus.s_axis_tready !== 1'b0 || amp_word_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got tv=%b td=%h rdy=%b awv=%b busy=%b, want 1 0012c000 0 0 1",
                         i, bus.m_axis_config_tvalid, bus.m_axis_config_tdata, bus.s_axis_tready,
                         amp_word_valid, busy);
            end
        end
        bus.m_axis_config_tready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.m_axis_config_tvalid !== 1'b0 || bus.s_axis_tready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_handshake: got tv=%b rdy=%b busy=%b, want 0 1 0",
                     bus.m_axis_config_tvalid, bus.s_axis_tready, busy);
        end
        @(negedge clk);
        vectors++;
        if (bus.s_axis_tready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_accept: got rdy=%b busy=%b, want 0 1", bus.s_axis_tready, busy);
        end
        bus.s_axis_tvalid = 1'b0;
        wait_out(32'h00014000, 16'd500, "bp_second");
    endtask

    task automatic test_reset_mid_mul();
        int to;
        to = 0;
        while (bus.s_axis_tready !== 1'b1 && to < 50) begin
            @(negedge clk);
            to++;
        end
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_taddr  = 16'd100;
        bus.s_axis_tamp   = 25'd5000;
        amp_gain          = 16'h8000;
        @(posedge clk);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || bus.m_axis_config_tvalid !== 1'b0 || amp_word !== 16'h0 ||
            bus.m_axis_config_tdata !== 32'h0 || amp_word_valid !== 1'b0 || bus.s_axis_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_mul_reset: got busy=%b tv=%b aw=%h td=%h awv=%b rdy=%b, want all 0",
                     busy, bus.m_axis_config_tvalid, amp_word, bus.m_axis_config_tdata,
                     amp_word_valid, bus.s_axis_tready);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.s_axis_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_mul_release s_tready: got %b, want 1", bus.s_axis_tready);
        end
        do_frame(16'd3, 25'd123456, 16'h4000, 1'b1, 32'h00003000, 16'd61728, "after_reset");
    endtask

`ifdef PEAK_AVG_EN
    task automatic test_avg();
        do_frame(16'd5, 25'd100, 16'h8000, 1'b0, 32'h0, 16'h0, "avg_f0");
        do_frame(16'd5, 25'd200, 16'h8000, 1'b0, 32'h0, 16'h0, "avg_f1");
        do_frame(16'd5, 25'd300, 16'h8000, 1'b0, 32'h0, 16'h0, "avg_f2");
        do_frame(16'd5, 25'd400, 16'h8000, 1'b1, 32'h00005000, 16'd250, "avg_f3");
    endtask
`endif

    task automatic test_random();
        logic [15:0] bin;
        logic [24:0] amp;
        logic [15:0] gain;
        for (int i = 0; i < 24; i++) begin
            bin  = 16'($urandom_range(0, 65535));
            amp  = (i % 3 == 0) ? 25'($urandom_range(0, 33554431)) : 25'($urandom_range(0, 200000));
            gain = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
`ifdef PEAK_AVG_EN
            avg_sum += amp;
            avg_cnt++;
            if (avg_cnt == 4) begin
                do_frame(bin, amp, gain, 1'b1, model_tdata(bin), model_amp(avg_sum / 4, gain), "random");
                avg_sum = 0;
                avg_cnt = 0;
            end else begin
                do_frame(bin, amp, gain, 1'b0, 32'h0, 16'h0, "random_skip");
            end
`else
            do_frame(bin, amp, gain, 1'b1, model_tdata(bin), model_amp(amp, gain), "random");
`endif
        end
    endtask

    initial begin
        vectors                  = 0;
        miscompares              = 0;
        rst                      = 1'b0;
        amp_gain                 = 16'h0;
        bus.s_axis_tvalid        = 1'b0;
        bus.s_axis_taddr         = '0;
        bus.s_axis_tamp          = '0;
        bus.m_axis_config_tready = 1'b1;
`ifdef PEAK_AVG_EN
        avg_sum = 0;
        avg_cnt = 0;
`endif

        test_reset();
`ifdef PEAK_AVG_EN
        test_avg();
        test_random();
`else
        test_basic();
        test_fold();
        test_saturation();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/peak_to_dds_cfg.md
Name: peak_to_dds_cfg

Overview:
- Downstream consumer of the find-max / root chain.
- Takes the peak FFT bin index and the root-sum-square peak amplitude, and converts them into a DDS phase-increment config word plus a 16-bit amplitude word for the DDS amplitude multiplier.
- Implements the calibration stage between CORDIC root output and dds_compiler / AMP_MULT, using a sequential shift-add multiplier.

Parameters:
- ADDR_WIDTH, 16, FFT bin index width; FFT length N = 2^ADDR_WIDTH.
- AMP_WIDTH, 25, width of the root amplitude input.
- PHASE_WIDTH, 28, DDS phase accumulator width.
- PINC_PER_BIN, 4096, phase increment per FFT bin (2^PHASE_WIDTH*fs/(N*fclk)), unsigned, 32-bit constant.
- AMP_SHIFT, 15, right shift applied to amp*gain product.
- AVG_LOG2, 2, log2 of frames averaged (PEAK_AVG_EN only).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- s_axis_tvalid  in  1  peak result valid.
- s_axis_tready  out  1  block can accept a peak result.
- s_axis_taddr  in  ADDR_WIDTH  peak bin index, unsigned.
- s_axis_tamp  in  AMP_WIDTH  peak amplitude, unsigned.
- amp_gain  in  16  calibration gain, unsigned; sampled on accept.
- m_axis_config_tvalid  out  1  DDS config word valid.
- m_axis_config_tready  in  1  DDS accepts config (tie 1 if core has no tready).
- m_axis_config_tdata  out  32  {(32-PHASE_WIDTH) zeros, pinc[PHASE_WIDTH-1:0]}.
- amp_word  out  16  DDS amplitude word (amp = amp_word/2^16), held between updates.
- amp_word_valid  out  1  one-cycle pulse when amp_word updates.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst==0 at an edge), from any state including mid-MUL or OUT:
  - state→IDLE; iteration counter and accumulators cleared.
  - Outputs: s_axis_tready=0 during reset, 1 on the first cycle after reset; m_axis_config_tvalid=0; m_axis_config_tdata=0; amp_word=0; amp_word_valid=0; busy=0.
- States: IDLE, MUL, SAT, OUT.
- IDLE:
  - s_axis_tready=1.
  - On s_axis_tvalid&&s_axis_tready, latch bin, amp and amp_gain; go to MUL with counter 0.
  - Bin folding: if bin > N/2, use N-bin (mirror of the negative-frequency bin). bin==N/2 and bin==0 are used as-is (bin 0 gives pinc 0).
- MUL:
  - One shift-add iteration per cycle, LOOP = max(ADDR_WIDTH,16) iterations.
  - Computes pinc_prod = bin*PINC_PER_BIN and amp_prod = amp*amp_gain (AMP_WIDTH+16 bits) in parallel.
  - Leaves MUL after the LOOP-th iteration.
- SAT (1 cycle):
  - pinc = pinc_prod mod 2^PHASE_WIDTH (wrap, no saturation).
  - a = amp_prod >> AMP_SHIFT; amp_word_next = (a > 16'hFFFF) ? 16'hFFFF : a[15:0].
  - Registers m_axis_config_tdata, amp_word and amp_word_valid=1, and sets m_axis_config_tvalid=1; state→OUT.
- Latency: accept at edge k → tvalid and amp_word_valid high after edge k+LOOP+1 (17 cycles at defaults).
- OUT:
  - tvalid held, tdata stable until m_axis_config_tready at an edge; then tvalid=0 and state→IDLE.
  - amp_word_valid is high only in the first OUT cycle.
- s_axis_tready=0 in MUL, SAT and OUT. Inputs presented then are not consumed; no buffering.
- tvalid and tready both high in the first OUT cycle: transfer completes in that cycle; s_axis_tready rises the following cycle.

Optional Feature:
- Macro PEAK_AVG_EN.
- Defined:
  - Accepted amplitudes are summed over 2^AVG_LOG2 frames (accumulator AMP_WIDTH+AVG_LOG2 bits).
  - The MUL/SAT/OUT path runs only on the final frame of each group, using amp = sum>>AVG_LOG2, plus the bin and gain of that final frame.
  - Earlier frames return to IDLE the cycle after accept with no output.
  - The frame counter is cleared by reset.
- Undefined: every accepted frame produces an output.

Test Plan:
- Reset low 3 cycles, then release → all outputs 0 and s_axis_tready=1 on the first cycle after release.
- bin=10, amp=1000, gain=0x8000, tready=1 → after 17 cycles tdata=0x0000A000 (40960), amp_word=1000, amp_word_valid single pulse.
- bin=65535 (mirror→1), then bin=0, then bin=32768 → tdata 0x00001000, 0x00000000, 0x08000000.
- amp=0x1FFFFFF, gain=0xFFFF → amp_word=0xFFFF (saturated).
- tready low 5 cycles in OUT with s_axis_tvalid held high → tvalid/tdata stable, s_axis_tready=0, no new accept; accept occurs 1 cycle after tready handshake.
- Reset asserted at MUL iteration 8 → next cycle IDLE, tvalid=0, amp_word=0. With PEAK_AVG_EN: amps 100,200,300,400, gain 0x8000 → single output amp_word=250.
